// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, register addresses and control bit positions for the PIC core.
package pic_pkg;
    typedef enum logic [1:0] {IDLE, PEND, ACK1, VEC} state_t;
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_IMR  = 2'd1;
    localparam logic [1:0] A_BASE = 2'd2;
    localparam logic [1:0] A_EOI  = 2'd3;
    localparam int C_LEVEL  = 0;
    localparam int C_AEOI   = 1;
    localparam int C_ROT    = 2;
    localparam int EOI_SPEC = 7;
endpackage

// File: rtl/pic_prio_resolver.sv
// pic_prio_resolver: rotating-priority scan starting after rot_ptr; a set isr bit at or above
// the first request blocks it (fully nested).
module pic_prio_resolver #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [N_IRQ-1:0] isr,
    input  logic [IDX_W-1:0] rot_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    logic             done;
    logic [IDX_W-1:0] j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        done  = 1'b0;
        j     = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            j = IDX_W'((int'(rot_ptr) + 1 + k) % N_IRQ);
            if (!done && isr[j]) begin
                done = 1'b1;
            end else if (!done && req[j]) begin
                done  = 1'b1;
                valid = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/pic_core_param.sv
// pic_core_param: clocked 8259A-style interrupt controller with edge/level trigger, AEOI,
// rotating priority, two-pulse INTA vector handshake and spurious-vector path.
module pic_core_param
    import pic_pkg::*;
#(
    parameter int N_IRQ  = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(N_IRQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IRQ-1:0]  ir,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              int_o,
    input  logic              inta,
    output logic [DATA_W-1:0] vector,
    output logic              vector_valid
);
    state_t            state, state_n;
    logic [2:0]        ctrl;
    logic [N_IRQ-1:0]  imr, irr, isr, ir_q, irr_n, isr_n;
    logic [N_IRQ-1:0]  ack_set, eoi_clr, aeoi_clr;
    logic [DATA_W-1:0] base;
    logic [IDX_W-1:0]  rot_ptr, rot_n, idx_q, w_idx, e_idx, eoi_idx;
    logic              spur, w_valid, e_valid, wr_en, ack1, ack2;

    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_win (
        .req(irr & ~imr), .isr(isr), .rot_ptr(rot_ptr), .valid(w_valid), .idx(w_idx)
    );
    pic_prio_resolver #(.N_IRQ(N_IRQ)) u_eoi (
        .req(isr), .isr('0), .rot_ptr(rot_ptr), .valid(e_valid), .idx(e_idx)
    );

    assign int_o        = state == PEND || state == ACK1;
    assign vector_valid = state == VEC;

    always_comb begin
        wr_en    = cs && wr;
        ack1     = state == PEND && inta;
        ack2     = state == ACK1 && inta;
        ack_set  = ack1 && w_valid ? N_IRQ'(1) << w_idx : '0;
        eoi_idx  = wdata[EOI_SPEC] ? wdata[IDX_W-1:0] : e_idx;
        eoi_clr  = !(wr_en && addr == A_EOI) ? '0 :
                   wdata[EOI_SPEC] ? isr & (N_IRQ'(1) << eoi_idx) :
                   e_valid ? N_IRQ'(1) << e_idx : '0;
        aeoi_clr = ack2 && ctrl[C_AEOI] && !spur ? N_IRQ'(1) << idx_q : '0;
        // set after clear so a same-cycle EOI cannot cancel a fresh acknowledge
        isr_n    = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        irr_n    = ctrl[C_LEVEL] ? ir : (irr & ~ack_set) | (ir & ~ir_q);
        rot_n    = !ctrl[C_ROT] ? rot_ptr : |aeoi_clr ? idx_q : |eoi_clr ? eoi_idx : rot_ptr;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = w_valid ? PEND : IDLE;
            PEND:    state_n = inta ? ACK1 : w_valid ? PEND : IDLE;
            ACK1:    state_n = inta ? VEC : ACK1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ctrl    <= '0;
            imr     <= '1;
            irr     <= '0;
            isr     <= '0;
            ir_q    <= '0;
            base    <= '0;
            rot_ptr <= IDX_W'(N_IRQ - 1);
            idx_q   <= '0;
            spur    <= 1'b0;
            rdata   <= '0;
            vector  <= '0;
        end else begin
            state   <= state_n;
            ir_q    <= ir;
            irr     <= irr_n;
            isr     <= isr_n;
            rot_ptr <= rot_n;
            if (wr_en && addr == A_CTRL) ctrl <= wdata[2:0];
            if (wr_en && addr == A_IMR) imr <= wdata[N_IRQ-1:0];
            if (wr_en && addr == A_BASE) base <= wdata & ~DATA_W'((1 << IDX_W) - 1);
            if (cs && rd)
                rdata <= addr == A_CTRL ? DATA_W'(ctrl) :
                         addr == A_IMR  ? DATA_W'(imr)  :
                         addr == A_BASE ? DATA_W'(irr)  : DATA_W'(isr);
            if (ack1) begin
                idx_q <= w_valid ? w_idx : IDX_W'(N_IRQ - 1);
                spur  <= !w_valid;
            end
            if (ack2) vector <= base | DATA_W'(idx_q);
        end
    end
endmodule

// File: tb/tb_pic_core_param.sv
// tb_pic_core_param: directed scenarios plus a randomized edge-mode run checked against a
// fixed-priority nested-interrupt reference model.
module tb_pic_core_param;
    logic       clk = 0, rst_n = 0, cs = 0, wr = 0, rd = 0, inta = 0;
    logic [7:0] ir = 0, wdata = 0, rdata, vector;
    logic [1:0] addr = 0;
    logic       int_o, vector_valid;
    int         n_cmp = 0, n_bad = 0;

    pic_core_param dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .int_o(int_o), .inta(inta), .vector(vector),
        .vector_valid(vector_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1; wr = 1; addr = a; wdata = d;
        tick();
        cs = 0; wr = 0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        cs = 1; rd = 1; addr = a;
        tick();
        cs = 0; rd = 0;
        d = rdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        ir = m;
        tick();
        ir = 0;
    endtask

    task automatic ack(input string tag, input logic [7:0] exp);
        inta = 1; tick();
        inta = 0; tick();
        inta = 1; tick();
        check({tag, ".valid"}, vector_valid, 1);
        check({tag, ".vector"}, vector, exp);
        inta = 0; tick();
        check({tag, ".valid_drop"}, vector_valid, 0);
        check({tag, ".int_drop"}, int_o, 0);
    endtask

    function automatic int model_winner(logic [7:0] irr_m, logic [7:0] isr_m, logic [7:0] imr_m);
        for (int i = 0; i < 8; i++) begin
            if (isr_m[i]) return -1;
            if (irr_m[i] && !imr_m[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        logic [7:0] d, m_irr, m_isr, m_imr, m_base, p;
        int w, k;
        tick(); tick();
        check("rst.int_o", int_o, 0);
        check("rst.vector_valid", vector_valid, 0);
        check("rst.vector", vector, 0);
        check("rst.rdata", rdata, 0);
        rst_n = 1;
        rd_reg(2'd1, d); check("rst.imr", d, 8'hFF);
        rd_reg(2'd0, d); check("rst.ctrl", d, 8'h00);

        // 1: fixed priority, edge mode
        wr_reg(2'd0, 8'h00); wr_reg(2'd1, 8'h00); wr_reg(2'd2, 8'h47);
        pulse(8'h28);
        check("t1.int_early", int_o, 0);
        tick();
        check("t1.int_latency", int_o, 1);
        ack("t1.a", 8'h43);
        rd_reg(2'd3, d); check("t1.isr", d, 8'h08);
        rd_reg(2'd2, d); check("t1.irr", d, 8'h20);
        check("t1.nested_block", int_o, 0);
        wr_reg(2'd3, 8'h00);
        tick();
        check("t1.int_after_eoi", int_o, 1);
        ack("t1.b", 8'h45);
        wr_reg(2'd3, 8'h00);
        rd_reg(2'd3, d); check("t1.isr_clear", d, 8'h00);

        // 2: nesting
        pulse(8'h10); tick();
        ack("t2.a", 8'h44);
        pulse(8'h40); tick(); tick();
        check("t2.lower_blocked", int_o, 0);
        pulse(8'h02); tick();
        check("t2.higher_int", int_o, 1);
        ack("t2.b", 8'h41);
        rd_reg(2'd3, d); check("t2.isr", d, 8'h12);
        wr_reg(2'd3, 8'h00);
        rd_reg(2'd3, d); check("t2.isr_ns_eoi", d, 8'h10);
        wr_reg(2'd3, 8'h84);
        tick();
        ack("t2.c", 8'h46);
        wr_reg(2'd3, 8'h00);

        // 3: level mode, request withdrawn before acknowledge -> spurious
        wr_reg(2'd0, 8'h01);
        ir = 8'h04; tick(); tick();
        check("t3.int", int_o, 1);
        ir = 0; tick();
        ack("t3.spur", 8'h47);
        rd_reg(2'd3, d); check("t3.isr", d, 8'h00);

        // 4: AEOI + rotate
        wr_reg(2'd0, 8'h06);
        pulse(8'h01); tick();
        ack("t4.a", 8'h40);
        rd_reg(2'd3, d); check("t4.isr_aeoi", d, 8'h00);
        pulse(8'h03); tick();
        ack("t4.rot", 8'h41);
        tick();
        check("t4.int_ir0", int_o, 1);
        ack("t4.c", 8'h40);

        // 5: masking
        wr_reg(2'd0, 8'h00); wr_reg(2'd1, 8'hFF);
        pulse(8'h08); tick(); tick();
        check("t5.masked", int_o, 0);
        rd_reg(2'd2, d); check("t5.irr", d, 8'h08);
        wr_reg(2'd1, 8'hF7);
        tick();
        check("t5.unmask", int_o, 1);

        // 6: reset while in ACK1
        inta = 1; tick(); inta = 0;
        rst_n = 0; tick();
        check("t6.int_o", int_o, 0);
        check("t6.vector_valid", vector_valid, 0);
        rst_n = 1;
        inta = 1; tick(); inta = 0;
        check("t6.no_vector", vector_valid, 0);
        rd_reg(2'd3, d); check("t6.isr", d, 8'h00);
        rd_reg(2'd2, d); check("t6.irr", d, 8'h00);
        rd_reg(2'd1, d); check("t6.imr", d, 8'hFF);

        // randomized edge-mode run against the nested-priority model
        m_irr = 0; m_isr = 0;
        m_imr = 8'($urandom) & 8'($urandom);
        m_base = 8'($urandom) & 8'hF8;
        wr_reg(2'd0, 8'h00); wr_reg(2'd1, m_imr); wr_reg(2'd2, m_base | 8'h05);
        for (int it = 0; it < 24; it++) begin
            p = 8'($urandom_range(0, 255));
            pulse(p);
            m_irr |= p;
            tick();
            w = model_winner(m_irr, m_isr, m_imr);
            check("rnd.int_o", int_o, w >= 0);
            if (w >= 0) begin
                ack("rnd.ack", m_base | 8'(w));
                m_irr[w] = 1'b0;
                m_isr[w] = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, 7);
                    wr_reg(2'd3, 8'h80 | 8'(k));
                    m_isr[k] = 1'b0;
                end else begin
                    wr_reg(2'd3, 8'h00);
                    m_isr = m_isr & (m_isr - 8'd1);
                end
            end
            rd_reg(2'd2, d); check("rnd.irr", d, m_irr);
            rd_reg(2'd3, d); check("rnd.isr", d, m_isr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
